// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: owns the read pointer, fetches
// words from a 1R1W synchronous RAM and presents them on a valid/ready port.
module fifo_rd_ctrl #(
   parameter int width_p = 8,
   parameter int depth_p = 16,
   localparam int aw = $clog2(depth_p)
) (
   input  logic               rclk_i,
   input  logic               rreset_n_i,
   input  logic [aw:0]        wptr_gray_sync_i,
   output logic               rd_valid_o,
   output logic [aw-1:0]      rd_addr_o,
   input  logic [width_p-1:0] rd_data_i,
   output logic [aw:0]        rptr_gray_o,
   output logic               valid_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i,
   output logic               empty_o,
   output logic [aw:0]        count_o
);

   localparam logic [aw:0] one_c = 1;

   logic [aw:0] rbin;
   logic [aw:0] rgray;
   logic [aw:0] rbin_nxt;
   logic [aw:0] wbin;
   logic        valid_q;
   logic        fetch;

   // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
   always_comb begin
      wbin = '0;
      for (int i = 0; i <= aw; i++) begin
         wbin[i] = ^(wptr_gray_sync_i >> i);
      end
   end

   assign empty_o  = (rgray == wptr_gray_sync_i);
   assign count_o  = wbin - rbin;
   assign rbin_nxt = rbin + one_c;

   // Handshake: a word moves to the consumer on every edge where valid_o and
   // ready_i are both high; valid_o never drops without ready_i, and data_o
   // cannot change while valid_o & ~ready_i because no fetch happens then.
   assign fetch = rreset_n_i & ~empty_o & (~valid_q | ready_i);

   assign rd_valid_o  = fetch;
   assign rd_addr_o   = rbin[aw-1:0];
   assign rptr_gray_o = rgray;
   assign valid_o     = valid_q;
   assign data_o      = rd_data_i;

   always_ff @(posedge rclk_i or negedge rreset_n_i) begin
      if (!rreset_n_i) begin
         rbin    <= '0;
         rgray   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (fetch) begin
            rbin  <= rbin_nxt;
            rgray <= rbin_nxt ^ (rbin_nxt >> 1);
         end
         if (fetch) begin
            valid_q <= 1'b1;
         end else if (ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule
